// File: rtl/burst_mem_arbiter.sv
// Round-robin arbiter between N cache-line channels and one burst memory port.
// A granted line is split into BURST_LEN beats, lowest beat first. Read beats are
// reassembled into a full line, which is returned with a one-cycle ch_resp pulse.
module burst_mem_arbiter #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned BEAT_W    = 64,
  parameter int unsigned BURST_LEN = LINE_W / BEAT_W,
  parameter int unsigned ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [BEAT_W-1:0]          pmem_wdata,
  input  logic [BEAT_W-1:0]          pmem_rdata,
  input  logic                       pmem_resp,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id
);

  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned OffW = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] AddrMask = ~((ADDR_W'(1) << OffW) - ADDR_W'(1));
  localparam logic [CntW-1:0]   LastBeat = CntW'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]   LastCh   = ID_W'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  state_e              state_q;
  logic [ID_W-1:0]     rr_q;
  logic [ID_W-1:0]     grant_q;
  logic [CntW-1:0]     beat_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   rdata_q;
  logic [NUM_CH-1:0]   resp_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                pmem_read_q;
  logic                pmem_write_q;
  logic                busy_q;

  logic [NUM_CH-1:0]   req;
  logic                any_req;
  logic                found_hi;
  logic [ID_W-1:0]     pick_hi;
  logic [ID_W-1:0]     pick_lo;
  logic [ID_W-1:0]     pick;
  logic [LINE_W-1:0]   line_fill;
  logic [ID_W-1:0]     rr_next;

  // Round-robin pick: lowest requester at/above rr_q, else lowest requester overall (wrap).
  always_comb begin
    req      = ch_read | ch_write;
    any_req  = |req;
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_lo = ID_W'(i);
        if (i >= int'(rr_q)) begin
          pick_hi  = ID_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  // Current line with the incoming read beat merged into slot beat_q.
  always_comb begin
    line_fill = line_q;
    line_fill[beat_q*BEAT_W +: BEAT_W] = pmem_rdata;
  end

  assign rr_next = (grant_q == LastCh) ? '0 : grant_q + 1'b1;

  // Transfer FSM; all outputs registered so an async reset clears them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      grant_q      <= '0;
      beat_q       <= '0;
      line_q       <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
      addr_q       <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      resp_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q      <= pick;
            // Write wins if a channel illegally raises both.
            pmem_write_q <= ch_write[pick];
            pmem_read_q  <= ~ch_write[pick];
            addr_q       <= ch_address[pick*ADDR_W +: ADDR_W] & AddrMask;
            line_q       <= ch_wdata[pick*LINE_W +: LINE_W];
            beat_q       <= '0;
            busy_q       <= 1'b1;
            state_q      <= StBurst;
          end
        end
        StBurst: begin
          if (pmem_resp) begin
            if (pmem_read_q) begin
              line_q <= line_fill;
            end
            if (beat_q == LastBeat) begin
              beat_q       <= '0;
              pmem_read_q  <= 1'b0;
              pmem_write_q <= 1'b0;
              resp_q       <= NUM_CH'(1) << grant_q;
              if (pmem_read_q) begin
                rdata_q <= line_fill;
              end
              state_q <= StDone;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        StDone: begin
          rr_q    <= rr_next;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ch_rdata     = rdata_q;
  assign ch_resp      = resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = pmem_write_q ? line_q[beat_q*BEAT_W +: BEAT_W] : '0;
  assign busy         = busy_q;
  assign grant_id     = grant_q;

  // A channel raising read and write together is a requester bug; it is served as a write.
  property p_no_read_and_write;
    @(posedge clk) disable iff (rst) (state_q == StIdle) |-> ((ch_read & ch_write) == '0);
  endproperty
  assert property (p_no_read_and_write)
    else $warning("burst_mem_arbiter: read and write both set on one channel, served as write");

endmodule

// File: tb/tb_burst_mem_arbiter.sv
// Directed bench: dut_a uses default parameters, dut_b has 4 channels of 8 x 32-bit beats.
module tb_burst_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // dut_a: NUM_CH=2, 4 beats of 64 bits
  logic [1:0]   a_read = '0, a_write = '0;
  logic [63:0]  a_addr = '0;
  logic [511:0] a_wdata = '0;
  logic [255:0] a_rdata;
  logic [1:0]   a_resp;
  logic         a_pread, a_pwrite, a_busy;
  logic [31:0]  a_paddr;
  logic [63:0]  a_pwdata;
  logic [63:0]  a_prdata = '0;
  logic         a_presp = 1'b0;
  logic [0:0]   a_gid;

  // dut_b: NUM_CH=4, 8 beats of 32 bits
  logic [3:0]    b_read = '0, b_write = '0;
  logic [127:0]  b_addr = '0;
  logic [1023:0] b_wdata = '0;
  logic [255:0]  b_rdata;
  logic [3:0]    b_resp;
  logic          b_pread, b_pwrite, b_busy;
  logic [31:0]   b_paddr;
  logic [31:0]   b_pwdata;
  logic [31:0]   b_prdata = '0;
  logic          b_presp = 1'b0;
  logic [1:0]    b_gid;

  burst_mem_arbiter dut_a (
    .clk(clk), .rst(rst), .ch_read(a_read), .ch_write(a_write), .ch_address(a_addr),
    .ch_wdata(a_wdata), .ch_rdata(a_rdata), .ch_resp(a_resp), .pmem_read(a_pread),
    .pmem_write(a_pwrite), .pmem_address(a_paddr), .pmem_wdata(a_pwdata),
    .pmem_rdata(a_prdata), .pmem_resp(a_presp), .busy(a_busy), .grant_id(a_gid)
  );

  burst_mem_arbiter #(.NUM_CH(4), .BEAT_W(32)) dut_b (
    .clk(clk), .rst(rst), .ch_read(b_read), .ch_write(b_write), .ch_address(b_addr),
    .ch_wdata(b_wdata), .ch_rdata(b_rdata), .ch_resp(b_resp), .pmem_read(b_pread),
    .pmem_write(b_pwrite), .pmem_address(b_paddr), .pmem_wdata(b_pwdata),
    .pmem_rdata(b_prdata), .pmem_resp(b_presp), .busy(b_busy), .grant_id(b_gid)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait read on dut_a; beat k carries byte seed*(k+1). Called in the request cycle.
  task automatic read_a(input int g, input logic [31:0] exp_addr, input logic [7:0] seed,
                        input logic [1:0] clr);
    logic [255:0] line;
    line = '0;
    tick();
    chk("a_grant", a_gid, g);
    chk("a_pread", a_pread, 1);
    chk("a_paddr", a_paddr, exp_addr);
    for (int k = 0; k < 4; k++) begin
      a_prdata = {8{8'(seed * (k + 1))}};
      a_presp  = 1'b1;
      line[k*64 +: 64] = a_prdata;
      chk("a_resp_early", a_resp, 0);
      tick();
    end
    a_presp = 1'b0;
    chk("a_resp", a_resp, 2'(1) << g);
    chk("a_rdata", a_rdata, line);
    chk("a_pread_done", a_pread, 0);
    a_read = a_read & ~clr;
    tick();
    chk("a_resp_pulse", a_resp, 0);
    chk("a_busy_idle", a_busy, 0);
  endtask

  // Write on dut_a with a fixed number of wait cycles before each beat's pmem_resp.
  task automatic write_a(input int g, input logic [31:0] exp_addr, input logic [255:0] line,
                         input int waits, input logic [255:0] hold, input logic [1:0] clr);
    tick();
    chk("a_wgrant", a_gid, g);
    chk("a_pwrite", a_pwrite, 1);
    chk("a_pread_w", a_pread, 0);
    chk("a_wpaddr", a_paddr, exp_addr);
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < waits; w++) begin
        chk("a_wbeat_wait", a_pwdata, line[k*64 +: 64]);
        chk("a_wresp_early", a_resp, 0);
        tick();
      end
      a_presp = 1'b1;
      chk("a_wbeat", a_pwdata, line[k*64 +: 64]);
      tick();
      a_presp = 1'b0;
    end
    chk("a_wresp", a_resp, 2'(1) << g);
    chk("a_pwrite_done", a_pwrite, 0);
    chk("a_rdata_hold", a_rdata, hold);
    a_read  = a_read & ~clr;
    a_write = a_write & ~clr;
    tick();
    chk("a_wbusy_idle", a_busy, 0);
  endtask

  // Zero-wait read on dut_b (8 beats); beat k = {seed, g, k, C3}.
  task automatic read_b(input int g, input logic [31:0] exp_addr, input logic [7:0] seed,
                        input logic [3:0] clr);
    logic [255:0] line;
    line = '0;
    tick();
    chk("b_grant", b_gid, g);
    chk("b_pread", b_pread, 1);
    chk("b_paddr", b_paddr, exp_addr);
    for (int k = 0; k < 8; k++) begin
      b_prdata = {seed, 8'(g), 8'(k), 8'hC3};
      b_presp  = 1'b1;
      line[k*32 +: 32] = b_prdata;
      chk("b_resp_early", b_resp, 0);
      tick();
    end
    b_presp = 1'b0;
    chk("b_resp", b_resp, 4'(1) << g);
    chk("b_rdata", b_rdata, line);
    b_read = b_read & ~clr;
    tick();
    chk("b_busy_idle", b_busy, 0);
  endtask

  logic [255:0] wline;
  logic [255:0] line4;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_pread", a_pread, 0);
    chk("rst_pwrite", a_pwrite, 0);
    chk("rst_resp", a_resp, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_b_busy", b_busy, 0);
    rst = 1'b0;
    tick();

    // 1: ch0 read 0x64 -> 0x60, line {44,33,22,11}
    a_addr[31:0] = 32'h0000_0064;
    a_read       = 2'b01;
    read_a(0, 32'h0000_0060, 8'h11, 2'b01);
    chk("t1_line", a_rdata, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});

    // 2: ch1 write 0x8000_0020, 2 wait cycles per beat, rdata holds test 1 line
    wline = {64'hDEAD_9999_AAAA_BBBB, 64'h5555_6666_7777_8888,
             64'h1111_2222_3333_4444, 64'h0123_4567_89AB_BEEF};
    a_addr[63:32]    = 32'h8000_0020;
    a_wdata[511:256] = wline;
    a_write          = 2'b10;
    write_a(1, 32'h8000_0020, wline, 2,
            {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 2'b10);

    // 3: both channels read continuously -> 0,1,0,1
    a_addr[31:0]  = 32'h0000_1000;
    a_addr[63:32] = 32'h0000_205F;
    a_read        = 2'b11;
    read_a(0, 32'h0000_1000, 8'h05, 2'b00);
    read_a(1, 32'h0000_2040, 8'h07, 2'b00);
    read_a(0, 32'h0000_1000, 8'h09, 2'b00);
    read_a(1, 32'h0000_2040, 8'h0B, 2'b11);

    // 4: reset after two beats of a read, then the held request restarts cleanly
    a_addr[31:0] = 32'h0000_0100;
    a_read       = 2'b01;
    tick();
    chk("t4_pread", a_pread, 1);
    a_presp  = 1'b1;
    a_prdata = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    a_prdata = 64'hBBBB_BBBB_BBBB_BBBB;
    tick();
    a_presp = 1'b0;
    rst = 1'b1;
    #1;
    chk("t4_rst_pread", a_pread, 0);
    chk("t4_rst_busy", a_busy, 0);
    chk("t4_rst_resp", a_resp, 0);
    tick();
    chk("t4_rst_resp2", a_resp, 0);
    rst = 1'b0;
    read_a(0, 32'h0000_0100, 8'h21, 2'b01);
    for (int k = 0; k < 4; k++) line4[k*64 +: 64] = {8{8'(8'h21 * (k + 1))}};

    // 5: read and write both high on ch0 -> served as write
    wline = {64'h0F0F_0F0F_0000_0004, 64'h0F0F_0F0F_0000_0003,
             64'h0F0F_0F0F_0000_0002, 64'h0F0F_0F0F_0000_0001};
    a_addr[31:0]   = 32'h0000_0040;
    a_wdata[255:0] = wline;
    a_read         = 2'b01;
    a_write        = 2'b01;
    write_a(0, 32'h0000_0040, wline, 0, line4, 2'b01);

    // 6: 4 channels, 8-beat bursts, all requesting -> 0,1,2,3,0
    for (int i = 0; i < 4; i++) b_addr[i*32 +: 32] = 32'h0000_1000 * (i + 1) + 32'h1F;
    b_read = 4'hF;
    read_b(0, 32'h0000_1000, 8'h50, 4'h0);
    read_b(1, 32'h0000_2000, 8'h51, 4'h0);
    read_b(2, 32'h0000_3000, 8'h52, 4'h0);
    read_b(3, 32'h0000_4000, 8'h53, 4'h0);
    read_b(0, 32'h0000_1000, 8'h54, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
